// File: rtl/pwm_fade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_pkg
// Description : Shared constants and helpers for the PWM fade bank.
//               MODE_IMMEDIATE / MODE_FADE select how a write updates a
//               channel; pwm_max() gives the PWM period length for a width.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_fade_pkg;

  // Write modes carried on i_mode
  localparam logic MODE_IMMEDIATE = 1'b0;  // level and target jump together
  localparam logic MODE_FADE      = 1'b1;  // only target moves; level walks to it

  // Largest duty level, equal to the PWM period in clocks
  function automatic int pwm_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage : pwm_fade_pkg
`default_nettype wire

// File: rtl/pwm_fade_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_channel
// Description : One PWM channel with its own fade engine. Holds the current
//               level, the target it walks toward, and the duty value that is
//               frozen for the running PWM period.
// Ports       : i_clk       fabric clock
//               i_reset_n   synchronous reset, active-low
//               i_cnt       shared PWM period counter
//               i_boundary  last cycle of the PWM period
//               i_tick      fade step strobe (coincides with a boundary)
//               i_wr_en     write strobe already decoded for this channel
//               i_mode      MODE_IMMEDIATE / MODE_FADE
//               i_target    written target level
//               o_pwm       registered PWM output (polarity per INVERT)
//               o_busy      level differs from target
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_channel
  import pwm_fade_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_boundary,
  input  logic             i_tick,
  input  logic             i_wr_en,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_target,
  output logic             o_pwm,
  output logic             o_busy
);

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_duty;
  logic             r_pwm;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_level  <= '0;
      r_target <= '0;
      r_duty   <= '0;
      r_pwm    <= INVERT;
    end else begin
      // Duty is captured only at the period boundary, using the level as it
      // stands before any step taken on the same edge, so a period is never
      // cut short or stretched by a change.
      if (i_boundary) begin
        r_duty <= r_level;
      end

      // A write takes priority over a fade step on the same edge.
      if (i_wr_en) begin
        r_target <= i_target;
        if (i_mode == MODE_IMMEDIATE) begin
          r_level <= i_target;
        end
      end else if (i_tick) begin
        if (r_level < r_target) begin
          r_level <= r_level + WIDTH'(1);
        end else if (r_level > r_target) begin
          r_level <= r_level - WIDTH'(1);
        end
      end

      // cnt never reaches MAX, so duty MAX is always active and duty 0 never.
      r_pwm <= (i_cnt < r_duty) ^ INVERT;
    end
  end

  assign o_pwm  = r_pwm;
  assign o_busy = (r_level != r_target);

endmodule : pwm_fade_channel
`default_nettype wire

// File: rtl/pwm_fade_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_bank
// Description : Bank of CHANNELS PWM outputs, each with an autonomous fade
//               engine. Shares one period counter and one fade-divider
//               counter across all channels and decodes register writes.
// Ports       : i_clk       fabric clock, rising edge
//               i_reset_n   synchronous reset, active-low
//               i_write     one-cycle write strobe
//               i_channel   channel index for the write
//               i_mode      0: immediate set, 1: fade to target
//               i_target    target duty level 0..MAX
//               o_pwm       PWM outputs, one per channel
//               o_busy      per channel, high while level != target
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_bank
  import pwm_fade_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int FADE_DIV = 4,
  parameter bit INVERT   = 1'b1,
  localparam int c_CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_write,
  input  logic [c_CH_W-1:0]   i_channel,
  input  logic                i_mode,
  input  logic [WIDTH-1:0]    i_target,
  output logic [CHANNELS-1:0] o_pwm,
  output logic [CHANNELS-1:0] o_busy
);

  localparam logic [WIDTH-1:0]  c_MAX   = WIDTH'(pwm_max(WIDTH));
  localparam logic [WIDTH-1:0]  c_LAST  = c_MAX - WIDTH'(1);
  localparam int                c_PC_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [c_PC_W-1:0] c_PLAST = c_PC_W'(FADE_DIV - 1);

  logic [WIDTH-1:0]    r_cnt;
  logic [c_PC_W-1:0]   r_pcnt;
  logic                w_boundary;
  logic                w_tick;
  logic [CHANNELS-1:0] w_wr_en;

  assign w_boundary = (r_cnt == c_LAST);
  assign w_tick     = w_boundary && (r_pcnt == c_PLAST);

  // Period counter runs 0..MAX-1 so one PWM period is exactly MAX clocks.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_boundary) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // Counts whole periods; wraps on the fade tick.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pcnt <= '0;
    end else if (w_boundary) begin
      if (r_pcnt == c_PLAST) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + c_PC_W'(1);
      end
    end
  end

  // Indices at or above CHANNELS match no channel, so such writes vanish.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_wr_en[c] = i_write && (i_channel == c_CH_W'(c));

    pwm_fade_channel #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT)
    ) u_channel (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_cnt      (r_cnt),
      .i_boundary (w_boundary),
      .i_tick     (w_tick),
      .i_wr_en    (w_wr_en[c]),
      .i_mode     (i_mode),
      .i_target   (i_target),
      .o_pwm      (o_pwm[c]),
      .o_busy     (o_busy[c])
    );
  end : g_ch

endmodule : pwm_fade_bank
`default_nettype wire

// File: tb/tb_pwm_fade_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_bank
// Description : Self-checking bench for pwm_fade_bank with WIDTH=4 (period
//               15 clocks), CHANNELS=3, FADE_DIV=2. Two instances share the
//               stimulus: one active-high, one active-low. Duty is checked
//               by counting high samples over one full PWM period; fade
//               timing is checked against the bench's own cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic [1:0] chn;
  logic       mode;
  logic [3:0] tgt;
  logic [2:0] pwm0, busy0, pwm1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_fade_bank #(.CHANNELS(3), .WIDTH(4), .FADE_DIV(2), .INVERT(1'b0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_write(wr), .i_channel(chn),
    .i_mode(mode), .i_target(tgt), .o_pwm(pwm0), .o_busy(busy0)
  );

  pwm_fade_bank #(.CHANNELS(3), .WIDTH(4), .FADE_DIV(2), .INVERT(1'b1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_write(wr), .i_channel(chn),
    .i_mode(mode), .i_target(tgt), .o_pwm(pwm1), .o_busy(busy1)
  );

  // Edges since the last reset edge: period counter = cyc mod 15,
  // boundaries land on edges 15m, fade ticks on edges 30j.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Edge number on which each busy bit of the active-high instance fell.
  int         fall_cyc [3];
  logic [2:0] prev_busy;
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++)
      if (prev_busy[c] === 1'b1 && busy0[c] === 1'b0) fall_cyc[c] = cyc;
    prev_busy = busy0;
  end

  typedef struct {
    logic [1:0] ch;
    logic [3:0] tgt;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic goto_cyc(input int k);
    int guard = 0;
    while (cyc != k) begin
      if (cyc > k || guard > 2000) begin
        $display("FAIL goto: cycle %0d cannot reach %0d", cyc, k);
        n_err++;
        $fatal(1, "bench sequencing lost");
      end
      step();
      guard++;
    end
  endtask

  task automatic do_write(input logic [1:0] c, input logic m, input logic [3:0] t);
    wr = 1'b1; chn = c; mode = m; tgt = t;
    step();
    wr = 1'b0;
  endtask

  // Observe the period whose counter run starts on edge 'start' (samples
  // after edges start+1..start+15). Optionally inject a write on edge start+2.
  task automatic measure(input int start, input bit do_wr, input logic [1:0] wch,
                         input logic wmode, input logic [3:0] wtgt,
                         input int e0, input int e1, input int e2, input string tag);
    int cnt [3];
    int inv_bad;
    cnt = '{0, 0, 0};
    inv_bad = 0;
    goto_cyc(start);
    for (int i = 0; i < 15; i++) begin
      if (do_wr && i == 1) begin
        wr = 1'b1; chn = wch; mode = wmode; tgt = wtgt;
      end else begin
        wr = 1'b0;
      end
      step();
      for (int c = 0; c < 3; c++) if (pwm0[c] === 1'b1) cnt[c]++;
      if (pwm1 !== ~pwm0) inv_bad++;
    end
    wr = 1'b0;
    check({tag, " duty ch0"}, cnt[0], e0);
    check({tag, " duty ch1"}, cnt[1], e1);
    check({tag, " duty ch2"}, cnt[2], e2);
    check({tag, " inverted copy"}, inv_bad, 0);
  endtask

  initial begin
    int   p0, p1, p2;
    int   exp1 [8];
    rst_n = 1'b0; wr = 1'b0; chn = '0; mode = 1'b0; tgt = '0;
    fall_cyc = '{-1, -1, -1};

    tbl[0] = '{2'd0, 4'd5,  5,  0,  0};
    tbl[1] = '{2'd2, 4'd15, 5,  0,  15};
    tbl[2] = '{2'd1, 4'd7,  5,  7,  15};
    tbl[3] = '{2'd2, 4'd0,  5,  7,  0};
    tbl[4] = '{2'd3, 4'd9,  5,  7,  0};   // out-of-range channel: ignored
    tbl[5] = '{2'd0, 4'd15, 15, 7,  0};
    tbl[6] = '{2'd1, 4'd0,  15, 0,  0};
    tbl[7] = '{2'd0, 4'd1,  1,  0,  0};

    // Reset state
    step(); step();
    check("reset pwm active-high", int'(pwm0), 0);
    check("reset pwm active-low", int'(pwm1), 7);
    check("reset busy", int'(busy0), 0);
    rst_n = 1'b1;

    // Immediate writes: old duty holds for the period containing the write,
    // new duty shows in the following period.
    p0 = 0; p1 = 0; p2 = 0;
    for (int i = 0; i < 8; i++) begin
      measure(30 + 30 * i, 1'b1, tbl[i].ch, 1'b0, tbl[i].tgt, p0, p1, p2,
              $sformatf("vec%0d old", i));
      measure(45 + 30 * i, 1'b0, 2'd0, 1'b0, 4'd0, tbl[i].e0, tbl[i].e1, tbl[i].e2,
              $sformatf("vec%0d new", i));
      check($sformatf("vec%0d busy", i), int'(busy0 | busy1), 0);
      p0 = tbl[i].e0; p1 = tbl[i].e1; p2 = tbl[i].e2;
    end

    // Fade ch1 0 -> 3, written on edge 302; steps land on edges 330/360/390.
    fall_cyc = '{-1, -1, -1};
    goto_cyc(301);
    do_write(2'd1, 1'b1, 4'd3);
    check("fade1 busy after write", int'(busy0), 2);
    exp1 = '{0, 0, 1, 1, 2, 2, 3, 3};
    for (int k = 0; k < 8; k++)
      measure(315 + 15 * k, 1'b0, 2'd0, 1'b0, 4'd0, 1, exp1[k], 0,
              $sformatf("fade1 p%0d", k));
    check("fade1 busy fall edge", fall_cyc[1], 390);

    // ch0 fades 1 -> 10, ch2 fades 0 -> 5. Retarget ch0 to 2 on tick edge 570
    // while ch0 is at 4: ch0 holds at 4 there, ch2 steps to 4 normally.
    fall_cyc = '{-1, -1, -1};
    goto_cyc(451);
    do_write(2'd0, 1'b1, 4'd10);
    do_write(2'd2, 1'b1, 4'd5);
    check("fade2 busy after writes", int'(busy0), 5);
    goto_cyc(569);
    do_write(2'd0, 1'b1, 4'd2);
    check("retarget busy", int'(busy0), 5);
    measure(600, 1'b0, 2'd0, 1'b0, 4'd0, 4, 3, 4, "retarget p600");
    measure(615, 1'b0, 2'd0, 1'b0, 4'd0, 3, 3, 5, "retarget p615");
    measure(645, 1'b0, 2'd0, 1'b0, 4'd0, 2, 3, 5, "retarget p645");
    check("retarget ch0 fall edge", fall_cyc[0], 630);
    check("fade ch2 fall edge", fall_cyc[2], 600);
    check("fades done busy", int'(busy0), 0);

    // Reset in the middle of a ch1 fade
    goto_cyc(661);
    do_write(2'd1, 1'b1, 4'd12);
    goto_cyc(700);
    check("mid-fade busy", int'(busy0), 2);
    rst_n = 1'b0;
    step();
    check("mid reset pwm active-high", int'(pwm0), 0);
    check("mid reset pwm active-low", int'(pwm1), 7);
    check("mid reset busy", int'(busy0 | busy1), 0);
    rst_n = 1'b1;
    // Counter must restart: a write on edge 2 shows exactly in period 15..29.
    measure(0, 1'b1, 2'd0, 1'b0, 4'd5, 0, 0, 0, "post reset old");
    measure(15, 1'b0, 2'd0, 1'b0, 4'd0, 5, 0, 0, "post reset new");
    measure(45, 1'b0, 2'd0, 1'b0, 4'd0, 5, 0, 0, "post reset fade aborted");
    check("post reset busy", int'(busy0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pwm_fade_bank
`default_nettype wire
